// File: rtl/exe_mem_pkg.sv
// Shared types and widths for the EXE->MEM pipeline boundary.
// Payload layout, LSB first: dst[4:0], st_val[36:5], alu_result[68:37], pc[100:69].
package exe_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int EXE_CTRL_W = 3;
  localparam int EXE_DATA_W = 101;

  localparam int CTRL_WB_EN_BIT    = 2;
  localparam int CTRL_MEM_R_EN_BIT = 1;
  localparam int CTRL_MEM_W_EN_BIT = 0;

  localparam int DST_W        = 5;
  localparam int WORD_W       = 32;
  localparam int DST_LSB      = 0;
  localparam int ST_VAL_LSB   = DST_LSB + DST_W;
  localparam int ALU_RES_LSB  = ST_VAL_LSB + WORD_W;
  localparam int PC_LSB       = ALU_RES_LSB + WORD_W;

  function automatic logic [EXE_DATA_W-1:0] pack_exe_payload(
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] alu_result,
    input logic [WORD_W-1:0] st_val,
    input logic [DST_W-1:0]  dst
  );
    logic [EXE_DATA_W-1:0] p;
    p = '0;
    p[PC_LSB      +: WORD_W] = pc;
    p[ALU_RES_LSB +: WORD_W] = alu_result;
    p[ST_VAL_LSB  +: WORD_W] = st_val;
    p[DST_LSB     +: DST_W]  = dst;
    return p;
  endfunction

endpackage

// File: rtl/exe_mem_skid_stage.sv
// EXE->MEM stage register: valid/ready with an optional skid entry so in_ready is registered.
// Control enables are zeroed whenever no valid word is held; flush empties the stage next edge.
module exe_mem_skid_stage
  import exe_mem_pkg::*;
#(
  parameter int CTRL_W = EXE_CTRL_W,
  parameter int DATA_W = EXE_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  generate
    if (SKID) begin : g_skid_rdy
      assign in_ready = in_ready_q;
    end else begin : g_stall_rdy
      assign in_ready = (state_q == EMPTY) | out_ready;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (in_fire && SKID) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (out_fire) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end
    endcase
    // Payload is left as-is on flush; only the enables must read zero.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_exe_mem_skid_stage.sv
// Scoreboard bench: SKID=1 and SKID=0 instances share stimulus, each checked against its own word queue.
module tb_exe_mem_skid_stage;

  typedef struct {
    logic [2:0]   ctrl;
    logic [100:0] data;
  } word_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   in_ctrl = '0;
  logic [100:0] in_data = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;

  logic         s_in_ready, s_out_valid;
  logic [2:0]   s_out_ctrl;
  logic [100:0] s_out_data;
  logic [1:0]   s_occ;
  logic         z_in_ready, z_out_valid;
  logic [2:0]   z_out_ctrl;
  logic [100:0] z_out_data;
  logic [1:0]   z_occ;

  int errors = 0;
  int checks = 0;
  word_t exp_q[2][$];

  always #5 clk = ~clk;

  exe_mem_skid_stage #(.CTRL_W(3), .DATA_W(101), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .occupancy(s_occ)
  );

  exe_mem_skid_stage #(.CTRL_W(3), .DATA_W(101), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl),
    .out_data(z_out_data), .occupancy(z_occ)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // k=0: skid instance holds up to two words; k=1: stall register holds one.
  task automatic mon(input int k, input logic ov, input logic ir, input logic [2:0] oc,
                     input logic [100:0] od, input logic [1:0] occ);
    int    n;
    logic  exp_ir, ofire, ifire;
    word_t w;
    n      = exp_q[k].size();
    exp_ir = (k == 0) ? (n < 2) : (n == 0 || out_ready);
    chk($sformatf("occupancy[%0d]", k), 128'(occ), 128'(n));
    chk($sformatf("out_valid[%0d]", k), 128'(ov), 128'(n > 0));
    chk($sformatf("in_ready[%0d]", k), 128'(ir), 128'(exp_ir));
    if (n > 0) begin
      chk($sformatf("out_ctrl[%0d]", k), 128'(oc), 128'(exp_q[k][0].ctrl));
      chk($sformatf("out_data[%0d]", k), 128'(od), 128'(exp_q[k][0].data));
    end else begin
      chk($sformatf("bubble_ctrl[%0d]", k), 128'(oc), 128'(0));
    end
    ofire = (n > 0) && out_ready;
    ifire = in_valid && exp_ir;
    if (ofire) void'(exp_q[k].pop_front());
    if (flush) begin
      exp_q[k].delete();
    end else if (ifire) begin
      w.ctrl = in_ctrl;
      w.data = in_data;
      exp_q[k].push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, s_out_valid, s_in_ready, s_out_ctrl, s_out_data, s_occ);
      mon(1, z_out_valid, z_in_ready, z_out_ctrl, z_out_data, z_occ);
    end
  end

  task automatic step(input logic v, input logic [2:0] c, input logic [100:0] d,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 128'(s_out_valid), 128'(0));
    chk({tag, "_out_ctrl"},  128'(s_out_ctrl),  128'(0));
    chk({tag, "_out_data"},  128'(s_out_data),  128'(0));
    chk({tag, "_occupancy"}, 128'(s_occ),       128'(0));
    chk({tag, "_in_ready"},  128'(s_in_ready),  128'(1));
    chk({tag, "_in_ready0"}, 128'(z_in_ready),  128'(1));
    chk({tag, "_out_data0"}, 128'(z_out_data),  128'(0));
  endtask

  initial begin
    logic [100:0] rd;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    #11 rst = 1'b0;

    // Streaming
    for (int i = 1; i <= 8; i++) step(1'b1, 3'(i), 101'(i), 1'b1, 1'b0);
    idle(3);

    // Bubble with enables set
    for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 101'h55, 1'b1, 1'b0);

    // Backpressure: A, B, attempted C while full, hold, release
    step(1'b1, 3'b100, 101'hAA, 1'b0, 1'b0);
    step(1'b1, 3'b010, 101'hBB, 1'b0, 1'b0);
    step(1'b1, 3'b001, 101'hCC, 1'b0, 1'b0);
    step(1'b0, 3'b000, '0, 1'b0, 1'b0);
    step(1'b0, 3'b000, '0, 1'b0, 1'b0);
    idle(4);

    // Flush with concurrent input while full
    step(1'b1, 3'b011, 101'h11, 1'b0, 1'b0);
    step(1'b1, 3'b110, 101'h22, 1'b0, 1'b0);
    step(1'b1, 3'b111, 101'hDEAD, 1'b0, 1'b1);
    idle(3);

    // Reset mid-stream with two words held
    step(1'b1, 3'b011, 101'h33, 1'b0, 1'b0);
    step(1'b1, 3'b110, 101'h44, 1'b0, 1'b0);
    step(1'b0, 3'b000, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    exp_q[0].delete();
    exp_q[1].delete();
    in_valid  = 1'b1;
    in_ctrl   = 3'b101;
    in_data   = 101'h1234;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1 rst = 1'b0;
    step(1'b0, 3'b000, '0, 1'b1, 1'b0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rd = {5'($urandom), $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, 3'($urandom), rd,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    idle(5);
    @(negedge clk);
    #1;
    chk("drain0", 128'(exp_q[0].size()), 128'(0));
    chk("drain1", 128'(exp_q[1].size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid_stage.md
# exe_mem_skid_stage

Parametrised pipeline stage register between EXE and MEM, replacing the fixed-width stall register. It carries one control field and one payload field under a valid/ready handshake and can hold a second word in a skid entry, so `in_ready` is a registered signal with no combinational path from `out_ready`. It supports synchronous flush and guarantees that control enables read as zero on bubbles. With `SKID=0` it degrades to a single-entry stall register.

## Interface
- `CTRL_W`, 3: control enables (wb_en, mem_r_en, mem_w_en); forced to zero on bubble/flush
- `DATA_W`, 101: payload width (PC, alu_result, st_val, dst)
- `SKID`, 1: 1 = two-entry skid buffer; 0 = single entry, combinational `in_ready`
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: upstream word present
- `in_ready` out 1: stage accepts the word this cycle
- `in_ctrl` in CTRL_W: upstream control enables
- `in_data` in DATA_W: upstream payload
- `flush` in 1: synchronous discard of all held words
- `out_valid` out 1: `out_ctrl`/`out_data` hold a valid word
- `out_ready` in 1: downstream (MEM, memReady) accepts
- `out_ctrl` out CTRL_W: control of the head word; 0 when `out_valid`=0
- `out_data` out DATA_W: payload of the head word; holds its last value when invalid
- `occupancy` out 2: number of held words, 0..2

## Operation
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Entries: main (drives outputs) and skid (present only when SKID=1). State is EMPTY, ONE or FULL, encoded as occupancy 0/1/2.
- EMPTY: in_fire -> ONE, main <= in.
- ONE:
  - in_fire & out_fire -> ONE, main <= in.
  - in_fire & !out_fire -> FULL, skid <= in.
  - !in_fire & out_fire -> EMPTY.
  - no fire -> hold.
- FULL: in_ready=0. out_fire -> ONE, main <= skid. Otherwise hold both entries unchanged.
- SKID=0: FULL is unreachable; in_ready = !out_valid | out_ready.
- SKID=1: in_ready = (state != FULL), taken from a register.
- Flush has priority over everything. Next edge: state EMPTY, all ctrl bits 0. An in_fire in the same cycle is dropped; an out_fire in the same cycle still counts downstream.
- Order is strictly FIFO; no word is duplicated or lost without a flush.

## Timing
- Reset (async, immediate): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, state EMPTY. in_ready=1 during and after reset.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: out_ready low for N cycles -> at most 2 words absorbed (SKID=1); in_ready falls the cycle after the second accept.
- Flush asserted at edge k -> out_valid=0 from edge k; in_ready=1 from edge k.
- Outputs are glitch-free registers, except in_ready when SKID=0.

## Structure
- Shared package `exe_mem_pkg` holds:
  - state enum `skid_state_t` {EMPTY, ONE, FULL}
  - default widths `EXE_CTRL_W`=3 and `EXE_DATA_W`=101
  - field offset constants for packing PC, alu_result, st_val and dst into the payload
- No sub-module. Main and skid entries are plain registers inside `exe_mem_skid_stage`.

## Test plan
- Reset mid-stream: assert rst with occupancy=2 -> outputs 0 and in_ready=1 immediately; the next word (ctrl=3'b101, data=0x1234) appears on the next cycle.
- Streaming: 8 words, data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, one cycle after each input, occupancy=1 throughout.
- Backpressure (SKID=1): out_ready=0 while words A=0xAA and B=0xBB arrive -> occupancy=2, in_ready=0, out_data=0xAA held. Release -> 0xAA then 0xBB, no loss.
- Flush with concurrent input: FULL plus in_valid with flush=1 -> occupancy=0, out_ctrl=0 next cycle, incoming word never appears at the output.
- SKID=0: out_ready=0 with one word held -> in_ready=0 combinationally; in_ready=1 in the same cycle out_ready rises.
- Bubble masking: in_valid=0 with in_ctrl=3'b111 -> out_ctrl stays 3'b000.
